drops_step_sequencer: RTL and testbench
=======================================

# drops_step_sequencer

Game-step controller for the drops design. Generates the periodic game tick, turns the two player buttons into catcher moves, and sequences each step of the drop-field datapath through a request/acknowledge shift handshake with a random spawn column. Scores catches, counts lives, and runs the start/play/game-over flow. Sits between the `ui_in` buttons and the field/render datapath inside the top level.

## Interface
Parameters:
- `COLS`, 8: playfield columns; must be a power of two, ≥2.
- `TICK_DIV`, 1000: clock cycles per game step; must be ≥4.
- `LIVES`, 3: lives at game start, range 1..3.

Ports:
- `clk` in 1: single clock.
- `rst` in 1: reset, synchronous, active-high.
- `ena` in 1: design enable; 0 freezes all game state.
- `btn_left` in 1: asynchronous button, from `ui_in[1]`.
- `btn_right` in 1: asynchronous button, from `ui_in[0]`.
- `shift_ack` in 1: datapath has shifted the field one row down.
- `hit_in` in 1: drop was in the bottom row at `player_col`. Valid only when `shift_ack`=1.
- `miss_in` in 1: drop was in the bottom row elsewhere. Valid only when `shift_ack`=1.
- `shift_req` out 1: request a one-row field shift.
- `spawn_en` out 1: insert a drop in the top row on this shift.
- `spawn_col` out log2(COLS): column for the new drop.
- `player_col` out log2(COLS): catcher column.
- `score` out 8: catches, saturating.
- `lives` out 2: lives remaining.
- `game_over` out 1: high in OVER.

## Operation
- **States:** IDLE, WAIT, MOVE, SHIFT, SCORE, OVER.
- **Reset values:** IDLE; `shift_req`=0; `spawn_en`=0; `spawn_col`=0; `player_col`=COLS/2; `score`=0; `lives`=LIVES; `game_over`=0; tick counter 0; pending flags 0; LFSR 8'hA5.
- **Buttons:** each button passes through a 2-flop synchronizer and a rising-edge detector.
  - A detected edge sets that button's pending flag. The flags are cleared in MOVE.
- **IDLE:** any button edge does the following, then goes to WAIT:
  - `score`=0, `lives`=LIVES, `player_col`=COLS/2.
  - Tick counter 0, pending flags cleared.
- **WAIT:** the counter increments each cycle. When counter==TICK_DIV-1, go to MOVE and set counter to 0.
- **MOVE** (1 cycle):
  - Left pending only: `player_col`-1, saturating at 0.
  - Right pending only: `player_col`+1, saturating at COLS-1.
  - Both pending, or neither: no move.
  - Latch `spawn_col`=lfsr[log2(COLS)-1:0] and `spawn_en`=(lfsr[7:6]!=0), then go to SHIFT.
- **SHIFT:** `shift_req`=1; `spawn_en`/`spawn_col` are held stable.
  - On the cycle `shift_ack`=1, capture `hit_in`/`miss_in` and go to SCORE.
  - `shift_req` is 0 from the next cycle on.
  - `shift_ack` is ignored outside SHIFT.
- **SCORE** (1 cycle):
  - Hit: `score`+1, saturating at 255.
  - Miss: `lives`-1.
  - Both hit and miss: apply both.
  - If `lives` reaches 0, go to OVER; otherwise go to WAIT.
- **OVER:** `game_over`=1. A button edge goes to IDLE; `score` is kept until the next start.
- **LFSR:** 8-bit Galois, polynomial x^8+x^6+x^5+x^4+1. Advances every enabled cycle in every state.
- **`ena`=0:** state, counter, LFSR, pending flags and all outputs hold; the synchronizers keep running.
- **`rst` mid-operation** (including during SHIFT): the next edge gives reset values. Any outstanding request is abandoned; the datapath must drop it.

## Timing
- Button pin edge → pending flag set: 3 cycles.
- Move takes effect at the next tick: `player_col` changes 1 cycle after the counter reaches TICK_DIV-1.
- Tick at cycle t:
  - MOVE at t+1.
  - `shift_req` high from t+2.
  - `shift_ack` at cycle a ≥ t+2 (zero-wait ack allowed).
  - SCORE at a+1.
  - `score`/`lives` updated and visible at a+2, with WAIT counter = 0 at a+2.
- Step period = TICK_DIV + 3 + ack wait cycles.
- All outputs are registered.

## Structure
- **Package `drops_pkg`:**
  - State enum.
  - LFSR seed 8'hA5 and tap mask 8'hB8.
  - Constants `SCORE_MAX`=255 and `SPAWN_DENSITY_BITS`=[7:6].
- **Sub-module `drops_btn_edge`:** synchronizer plus edge detect, instantiated twice.

## Test plan
1. Assert `rst` 2 cycles → IDLE, `player_col`=4, `lives`=3, `score`=0, `shift_req`=0, `game_over`=0.
2. Right-button pulse in IDLE → WAIT within 4 cycles. First `shift_req` exactly TICK_DIV+1 cycles after entering WAIT, with `player_col` still 4 (start edge consumed).
3. Five left pulses, one per step, from column 4 → `player_col` 3,2,1,0,0. Both buttons pulsed in the same step → no change.
4. `shift_ack` delayed 3 cycles with `hit_in`=1 → `shift_req` high exactly 4 cycles, `spawn_col` stable throughout, `score` 0→1 two cycles after ack.
5. Three steps with `miss_in`=1 → `lives` 3,2,1,0; `game_over`=1 at the third a+2. Button pulse → IDLE; next start resets `score` to 0.
6. `rst` raised while `shift_req`=1 → `shift_req`=0 and IDLE on the next cycle. `ena`=0 for 50 cycles in WAIT → step delayed by exactly 50 cycles.

Source files
------------

// File: rtl/drops_pkg.sv
// Shared types and constants for the drops game-step controller.
package drops_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_MOVE,
    ST_SHIFT,
    ST_SCORE,
    ST_OVER
  } state_e;

  localparam logic [7:0] LFSR_SEED = 8'hA5;
  // Right-shifting Galois form of x^8+x^6+x^5+x^4+1.
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  localparam logic [7:0] SCORE_MAX = 8'd255;

  // A drop spawns whenever either of these LFSR bits is set (3 in 4 steps).
  localparam int SPAWN_DENSITY_HI = 7;
  localparam int SPAWN_DENSITY_LO = 6;

  function automatic logic [7:0] lfsr_next(input logic [7:0] cur);
    return {1'b0, cur[7:1]} ^ (cur[0] ? LFSR_TAPS : 8'h00);
  endfunction

endpackage

// File: rtl/drops_btn_edge.sv
// Two-flop synchronizer plus rising-edge detector for one asynchronous button.
module drops_btn_edge (
  input  logic clk,
  input  logic rst,
  input  logic btn_in,
  output logic rise_o
);

  logic sync1_q, sync2_q, prev_q;
  logic sync1_d, sync2_d, prev_d;

  // Shift chain: two synchronizer stages then the previous-value stage.
  always_comb begin
    sync1_d = btn_in;
    sync2_d = sync1_q;
    prev_d  = sync2_q;
  end

  // Runs regardless of the design enable so pins stay synchronized.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
    end
  end

  assign rise_o = sync2_q & ~prev_q;

endmodule

// File: rtl/drops_step_sequencer.sv
// Game-step controller: tick timer, catcher moves, field-shift handshake,
// scoring, lives and start/over flow.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_IDLE  | waiting for a button edge to start a game
//   ST_WAIT  | counting the game tick
//   ST_MOVE  | apply pending move, latch spawn column/enable
//   ST_SHIFT | shift_req high, waiting for shift_ack
//   ST_SCORE | apply captured hit/miss, decide WAIT or OVER
//   ST_OVER  | game_over high, button edge returns to IDLE
module drops_step_sequencer
  import drops_pkg::*;
#(
  parameter int COLS     = 8,
  parameter int TICK_DIV = 1000,
  parameter int LIVES    = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     ena,
  input  logic                     btn_left,
  input  logic                     btn_right,
  input  logic                     shift_ack,
  input  logic                     hit_in,
  input  logic                     miss_in,
  output logic                     shift_req,
  output logic                     spawn_en,
  output logic [$clog2(COLS)-1:0]  spawn_col,
  output logic [$clog2(COLS)-1:0]  player_col,
  output logic [7:0]               score,
  output logic [1:0]               lives,
  output logic                     game_over
);

  localparam int CW = $clog2(COLS);
  localparam int TW = $clog2(TICK_DIV);
  localparam logic [TW-1:0] TICK_LAST  = TW'(TICK_DIV - 1);
  localparam logic [CW-1:0] COL_HOME   = CW'(COLS / 2);
  localparam logic [CW-1:0] COL_MAX    = CW'(COLS - 1);
  localparam logic [1:0]    LIVES_INIT = 2'(LIVES);

  logic rise_l, rise_r;

  drops_btn_edge u_btn_left (
    .clk    (clk),
    .rst    (rst),
    .btn_in (btn_left),
    .rise_o (rise_l)
  );

  drops_btn_edge u_btn_right (
    .clk    (clk),
    .rst    (rst),
    .btn_in (btn_right),
    .rise_o (rise_r)
  );

  state_e          state_q, state_d;
  logic [TW-1:0]   cnt_q, cnt_d;
  logic [7:0]      lfsr_q, lfsr_d;
  logic            pend_l_q, pend_l_d, pend_r_q, pend_r_d;
  logic            hit_q, hit_d, miss_q, miss_d;
  logic            shift_req_q, shift_req_d;
  logic            spawn_en_q, spawn_en_d;
  logic [CW-1:0]   spawn_col_q, spawn_col_d;
  logic [CW-1:0]   player_col_q, player_col_d;
  logic [7:0]      score_q, score_d;
  logic [1:0]      lives_q, lives_d;
  logic            game_over_q, game_over_d;

  // Next-state and next-output logic; everything holds while ena is low.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    lfsr_d       = lfsr_q;
    pend_l_d     = pend_l_q;
    pend_r_d     = pend_r_q;
    hit_d        = hit_q;
    miss_d       = miss_q;
    shift_req_d  = shift_req_q;
    spawn_en_d   = spawn_en_q;
    spawn_col_d  = spawn_col_q;
    player_col_d = player_col_q;
    score_d      = score_q;
    lives_d      = lives_q;
    game_over_d  = game_over_q;

    if (ena) begin
      lfsr_d = lfsr_next(lfsr_q);

      // During play edges accumulate; MOVE consumes the old flags but an
      // edge landing in that same cycle is kept for the next step.
      if (state_q != ST_IDLE && state_q != ST_OVER) begin
        pend_l_d = ((state_q == ST_MOVE) ? 1'b0 : pend_l_q) | rise_l;
        pend_r_d = ((state_q == ST_MOVE) ? 1'b0 : pend_r_q) | rise_r;
      end

      case (state_q)
        ST_IDLE: begin
          if (rise_l | rise_r) begin
            score_d      = '0;
            lives_d      = LIVES_INIT;
            player_col_d = COL_HOME;
            cnt_d        = '0;
            pend_l_d     = 1'b0;
            pend_r_d     = 1'b0;
            state_d      = ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (cnt_q == TICK_LAST) begin
            cnt_d   = '0;
            state_d = ST_MOVE;
          end else begin
            cnt_d = cnt_q + TW'(1);
          end
        end
        ST_MOVE: begin
          if (pend_l_q && !pend_r_q) begin
            if (player_col_q != '0) player_col_d = player_col_q - CW'(1);
          end else if (pend_r_q && !pend_l_q) begin
            if (player_col_q != COL_MAX) player_col_d = player_col_q + CW'(1);
          end
          spawn_col_d = lfsr_q[CW-1:0];
          spawn_en_d  = |lfsr_q[SPAWN_DENSITY_HI:SPAWN_DENSITY_LO];
          shift_req_d = 1'b1;
          state_d     = ST_SHIFT;
        end
        ST_SHIFT: begin
          if (shift_ack) begin
            hit_d       = hit_in;
            miss_d      = miss_in;
            shift_req_d = 1'b0;
            state_d     = ST_SCORE;
          end
        end
        ST_SCORE: begin
          if (hit_q && score_q != SCORE_MAX) score_d = score_q + 8'd1;
          if (miss_q) lives_d = lives_q - 2'd1;
          if (miss_q && lives_q == 2'd1) begin
            game_over_d = 1'b1;
            state_d     = ST_OVER;
          end else begin
            state_d = ST_WAIT;
          end
        end
        ST_OVER: begin
          if (rise_l | rise_r) begin
            game_over_d = 1'b0;
            state_d     = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // State and registered outputs; reset abandons any outstanding shift.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      lfsr_q       <= LFSR_SEED;
      pend_l_q     <= 1'b0;
      pend_r_q     <= 1'b0;
      hit_q        <= 1'b0;
      miss_q       <= 1'b0;
      shift_req_q  <= 1'b0;
      spawn_en_q   <= 1'b0;
      spawn_col_q  <= '0;
      player_col_q <= COL_HOME;
      score_q      <= '0;
      lives_q      <= LIVES_INIT;
      game_over_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      lfsr_q       <= lfsr_d;
      pend_l_q     <= pend_l_d;
      pend_r_q     <= pend_r_d;
      hit_q        <= hit_d;
      miss_q       <= miss_d;
      shift_req_q  <= shift_req_d;
      spawn_en_q   <= spawn_en_d;
      spawn_col_q  <= spawn_col_d;
      player_col_q <= player_col_d;
      score_q      <= score_d;
      lives_q      <= lives_d;
      game_over_q  <= game_over_d;
    end
  end

  assign shift_req  = shift_req_q;
  assign spawn_en   = spawn_en_q;
  assign spawn_col  = spawn_col_q;
  assign player_col = player_col_q;
  assign score      = score_q;
  assign lives      = lives_q;
  assign game_over  = game_over_q;

endmodule

// File: tb/tb_drops_step_sequencer.sv
// Bench for drops_step_sequencer: behavioural game model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_drops_step_sequencer;

  localparam int COLS = 8;
  localparam int TD   = 20;
  localparam int LIVES = 3;

  logic clk = 1'b0;
  logic rst, ena, btn_left, btn_right, shift_ack, hit_in, miss_in;
  logic shift_req, spawn_en, game_over;
  logic [2:0] spawn_col, player_col;
  logic [7:0] score;
  logic [1:0] lives;

  int n_tests = 0;
  int n_fail  = 0;
  int ncyc    = 0;
  bit chk_on  = 1'b0;

  always #5 clk = ~clk;

  drops_step_sequencer #(.COLS(COLS), .TICK_DIV(TD), .LIVES(LIVES)) dut (
    .clk        (clk),
    .rst        (rst),
    .ena        (ena),
    .btn_left   (btn_left),
    .btn_right  (btn_right),
    .shift_ack  (shift_ack),
    .hit_in     (hit_in),
    .miss_in    (miss_in),
    .shift_req  (shift_req),
    .spawn_en   (spawn_en),
    .spawn_col  (spawn_col),
    .player_col (player_col),
    .score      (score),
    .lives      (lives),
    .game_over  (game_over)
  );

  always @(posedge clk) ncyc <= ncyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    n_tests++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, want, ncyc);
    end
  endtask

  // ---------------- behavioural model ----------------
  localparam int PH_IDLE = 0, PH_WAIT = 1, PH_MOVE = 2, PH_SHIFT = 3, PH_SCORE = 4, PH_OVER = 5;

  function automatic logic [7:0] m_lfsr_step(input logic [7:0] v);
    logic [7:0] r;
    r = v >> 1;
    if (v[0]) r = r ^ 8'hB8;
    return r;
  endfunction

  int m_phase, m_left, m_col, m_score, m_lives, m_scol;
  bit m_over, m_req, m_sen, m_pl, m_pr, m_hit, m_miss;
  logic [7:0] m_lfsr;
  bit [2:0] hl, hr;

  always @(posedge clk) begin
    bit el, er, accept;
    el = hl[1] && !hl[2];
    er = hr[1] && !hr[2];
    if (rst) begin
      hl = '0; hr = '0;
      m_phase = PH_IDLE; m_left = 0; m_col = COLS / 2; m_score = 0; m_lives = LIVES;
      m_over = 0; m_req = 0; m_sen = 0; m_scol = 0; m_pl = 0; m_pr = 0;
      m_hit = 0; m_miss = 0; m_lfsr = 8'hA5;
    end else begin
      hl = {hl[1:0], btn_left};
      hr = {hr[1:0], btn_right};
      if (ena) begin
        accept = (m_phase != PH_IDLE) && (m_phase != PH_OVER);
        case (m_phase)
          PH_IDLE: if (el || er) begin
            m_score = 0; m_lives = LIVES; m_col = COLS / 2;
            m_pl = 0; m_pr = 0; m_left = TD - 1; m_phase = PH_WAIT;
            accept = 0;
          end
          PH_WAIT: if (m_left == 0) m_phase = PH_MOVE; else m_left--;
          PH_MOVE: begin
            if (m_pl && !m_pr) m_col = (m_col > 0) ? m_col - 1 : 0;
            else if (m_pr && !m_pl) m_col = (m_col < COLS - 1) ? m_col + 1 : COLS - 1;
            m_pl = 0; m_pr = 0;
            m_scol = m_lfsr % COLS;
            m_sen  = (m_lfsr >= 64);
            m_req  = 1; m_phase = PH_SHIFT;
          end
          PH_SHIFT: if (shift_ack) begin
            m_hit = hit_in; m_miss = miss_in; m_req = 0; m_phase = PH_SCORE;
          end
          PH_SCORE: begin
            if (m_hit && m_score < 255) m_score++;
            if (m_miss) m_lives--;
            if (m_lives == 0) begin m_over = 1; m_phase = PH_OVER; end
            else begin m_left = TD - 1; m_phase = PH_WAIT; end
          end
          PH_OVER: if (el || er) begin m_over = 0; m_phase = PH_IDLE; end
          default: m_phase = PH_IDLE;
        endcase
        if (accept) begin
          if (el) m_pl = 1;
          if (er) m_pr = 1;
        end
        m_lfsr = m_lfsr_step(m_lfsr);
      end
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (chk_on) begin
      chk("m_shift_req",  shift_req,  m_req);
      chk("m_spawn_en",   spawn_en,   m_sen);
      chk("m_spawn_col",  spawn_col,  m_scol);
      chk("m_player_col", player_col, m_col);
      chk("m_score",      score,      m_score);
      chk("m_lives",      lives,      m_lives);
      chk("m_game_over",  game_over,  m_over);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic pulse(input bit l, input bit r);
    btn_left = l; btn_right = r;
    @(negedge clk);
    btn_left = 1'b0; btn_right = 1'b0;
  endtask

  // One game step: optional button pulse, wait for request, ack after d cycles.
  // Returns at the cycle after the ack (SCORE visible).
  task automatic run_step(input bit l, input bit r, input int d, input bit hit, input bit miss,
                          output int col_at_req, output int req_cycles, output int req_at);
    int k;
    logic [2:0] sc;
    if (l || r) pulse(l, r);
    k = 0;
    while (shift_req !== 1'b1 && k < 4 * TD + 100) begin
      @(negedge clk);
      k++;
    end
    chk("req_seen", shift_req, 1);
    col_at_req = player_col;
    req_at     = ncyc;
    sc         = spawn_col;
    req_cycles = 1;
    for (int i = 0; i < d; i++) begin
      @(negedge clk);
      if (shift_req) req_cycles++;
      chk("spawn_col_stable", spawn_col, sc);
    end
    shift_ack = 1'b1; hit_in = hit; miss_in = miss;
    @(negedge clk);
    shift_ack = 1'b0; hit_in = 1'b0; miss_in = 1'b0;
    chk("req_drop", shift_req, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  int col, rc, ra, prev_ra, t0, k;
  int exp_cols[5] = '{3, 2, 1, 0, 0};

  initial begin
    rst = 1'b1; ena = 1'b1; btn_left = 1'b0; btn_right = 1'b0;
    shift_ack = 1'b0; hit_in = 1'b0; miss_in = 1'b0;

    // model LFSR pinned to hand-stepped values
    chk("lfsr_step_a5", m_lfsr_step(8'hA5), 8'hEA);
    chk("lfsr_step_ea", m_lfsr_step(8'hEA), 8'h75);
    chk("lfsr_step_75", m_lfsr_step(8'h75), 8'h82);

    // 1: reset
    @(negedge clk);
    chk_on = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_player_col", player_col, 4);
    chk("rst_lives", lives, 3);
    chk("rst_score", score, 0);
    chk("rst_shift_req", shift_req, 0);
    chk("rst_game_over", game_over, 0);
    repeat (3) @(negedge clk);

    // 2: start with right pulse; start edge must not move the catcher
    t0 = ncyc;
    run_step(0, 1, 0, 0, 0, col, rc, ra);
    chk("start_to_req", ra - t0, TD + 4);
    chk("start_col", col, 4);
    @(negedge clk);
    prev_ra = ra;

    // 3: five left moves then right then both
    for (int i = 0; i < 5; i++) begin
      run_step(1, 0, 0, 0, 0, col, rc, ra);
      chk("left_col", col, exp_cols[i]);
      chk("step_period", ra - prev_ra, TD + 3);
      prev_ra = ra;
      @(negedge clk);
    end
    run_step(0, 1, 0, 0, 0, col, rc, ra);
    chk("right_col", col, 1);
    @(negedge clk);
    run_step(1, 1, 0, 0, 0, col, rc, ra);
    chk("both_col", col, 1);
    @(negedge clk);

    // 4: delayed ack with a hit
    run_step(0, 0, 3, 1, 0, col, rc, ra);
    chk("req_high_cycles", rc, 4);
    chk("score_before", score, 0);
    @(negedge clk);
    chk("score_after", score, 1);

    // 5: three misses to game over
    for (int i = 0; i < 3; i++) begin
      run_step(0, 0, 0, 0, 1, col, rc, ra);
      @(negedge clk);
      chk("miss_lives", lives, 2 - i);
      chk("miss_game_over", game_over, (i == 2) ? 1 : 0);
    end
    repeat (5) @(negedge clk);
    chk("over_hold", game_over, 1);
    chk("over_no_req", shift_req, 0);
    pulse(1, 0);
    repeat (4) @(negedge clk);
    chk("idle_game_over", game_over, 0);
    chk("idle_score_kept", score, 1);
    run_step(0, 1, 0, 0, 0, col, rc, ra);
    chk("restart_score", score, 0);
    chk("restart_lives", lives, 3);
    @(negedge clk);

    // 6a: reset while a request is outstanding
    k = 0;
    while (shift_req !== 1'b1 && k < 4 * TD + 100) begin
      @(negedge clk);
      k++;
    end
    chk("req_before_rst", shift_req, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_mid_req", shift_req, 0);
    chk("rst_mid_col", player_col, 4);
    chk("rst_mid_lives", lives, 3);
    repeat (3) @(negedge clk);

    // 6b: ena low for 50 cycles in WAIT delays the step by exactly 50
    run_step(0, 1, 0, 0, 0, col, rc, ra);
    prev_ra = ra;
    @(negedge clk);
    repeat (5) @(negedge clk);
    ena = 1'b0;
    repeat (50) @(negedge clk);
    ena = 1'b1;
    run_step(0, 0, 0, 0, 0, col, rc, ra);
    chk("freeze_period", ra - prev_ra, TD + 3 + 50);
    repeat (4) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
